// File: rtl/tiled_matmul_ctrl.sv
// tiled_matmul_ctrl -- sequencing controller for a tiled matrix multiply
//   C(MxN) = A(MxP) x B(PxN)
//
// Walks the tile grid with the inner dimension varying fastest. Then the
// column tile varies, then the row tile. For each tile it performs these steps:
//   1. Request the A/B tile fetch and wait for both fetch acknowledges.
//   2. Load the multiplier (one-cycle pulse).
//   3. Hold mul_start until mul_done is returned.
//   4. Request accumulation into C and wait for acc_done.
//      acc_clear is set on the first inner step of each C tile.
// No arithmetic on data happens here. DATA_W only documents the datapath width.
//
// Optional build macro: MATMUL_PERF_CNT_EN adds the cyc_cnt and tile_cnt
// performance counter outputs.
//
// Ports:
//   clk, rst (async, active-high)
//   start, abort                 job control (start is sampled only in IDLE)
//   busy, done                   job active / one-cycle completion pulse
//   fetch_req, fetch_done_a/b    tile fetch handshake
//   a_row/a_col/b_row/b_col      origins of the current A and B tiles
//   tile_rows/inner/cols         valid extent of the current tile (edge clipped)
//   mul_load, mul_start/mul_done multiplier handshake
//   acc_req/acc_done, acc_clear  accumulate handshake, clear on first inner step
//   c_row, c_col                 origin of the current C tile
//   cyc_cnt, tile_cnt            (MATMUL_PERF_CNT_EN) busy cycles, ACC handshakes
module tiled_matmul_ctrl #(
  parameter int DATA_W = 16,
  parameter int M      = 4,
  parameter int P      = 4,
  parameter int N      = 4,
  parameter int TM     = 2,
  parameter int TK     = 2,
  parameter int TN     = 2,
  parameter int IDX_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             fetch_req,
  output logic [IDX_W-1:0] a_row,
  output logic [IDX_W-1:0] a_col,
  output logic [IDX_W-1:0] b_row,
  output logic [IDX_W-1:0] b_col,
  input  logic             fetch_done_a,
  input  logic             fetch_done_b,
  output logic [IDX_W-1:0] tile_rows,
  output logic [IDX_W-1:0] tile_inner,
  output logic [IDX_W-1:0] tile_cols,
  output logic             mul_load,
  output logic             mul_start,
  input  logic             mul_done,
  output logic             acc_req,
  output logic             acc_clear,
  output logic [IDX_W-1:0] c_row,
  output logic [IDX_W-1:0] c_col,
  input  logic             acc_done
`ifdef MATMUL_PERF_CNT_EN
  ,
  output logic [31:0]      cyc_cnt,
  output logic [IDX_W-1:0] tile_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, MUL_LOAD, MUL_WAIT, ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] i, l, r;
  logic [IDX_W-1:0] i_nxt, l_nxt, r_nxt;
  logic             fa, fb;
  logic             start_ok, abort_ok, fetch_go, acc_hs;
  logic             last_r, last_l, last_i;

  // Remaining extent clipped to the tile size. All operands are widened to
  // 32 bits, so no sum can wrap near the 1023 limit.
  function automatic logic [IDX_W-1:0] clip(input logic [31:0] t, input logic [31:0] rem);
    return IDX_W'((t < rem) ? t : rem);
  endfunction

  assign start_ok = (state == IDLE) && start;
  assign abort_ok = (state != IDLE) && abort;
  // A latched or same-cycle acknowledge counts, so the last one to arrive
  // moves on without an extra cycle.
  assign fetch_go = (fa || fetch_done_a) && (fb || fetch_done_b);
  assign acc_hs   = (state == ACC) && acc_done && !abort;

  assign last_r = (32'(r) + 32'(TK)) >= 32'(P);
  assign last_l = (32'(l) + 32'(TN)) >= 32'(N);
  assign last_i = (32'(i) + 32'(TM)) >= 32'(M);

  // Next tile coordinates, inner dimension first.
  always_comb begin
    r_nxt = last_r ? '0 : IDX_W'(32'(r) + 32'(TK));
    l_nxt = l;
    i_nxt = i;
    if (last_r) begin
      l_nxt = last_l ? '0 : IDX_W'(32'(l) + 32'(TN));
      if (last_l) i_nxt = last_i ? '0 : IDX_W'(32'(i) + 32'(TM));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_ok) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (start)    state_nxt = FETCH;
        FETCH:    if (fetch_go) state_nxt = MUL_LOAD;
        MUL_LOAD:               state_nxt = MUL_WAIT;
        MUL_WAIT: if (mul_done) state_nxt = ACC;
        ACC:      if (acc_done) state_nxt = (last_r && last_l && last_i) ? DONE : FETCH;
        DONE:                   state_nxt = IDLE;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  // Tile indices and fetch acknowledge latches. Both clear on abort, so the
  // next job starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i  <= '0;
      l  <= '0;
      r  <= '0;
      fa <= 1'b0;
      fb <= 1'b0;
    end else if (abort_ok || start_ok) begin
      i  <= '0;
      l  <= '0;
      r  <= '0;
      fa <= 1'b0;
      fb <= 1'b0;
    end else begin
      if (state == FETCH) begin
        fa <= fetch_go ? 1'b0 : (fa || fetch_done_a);
        fb <= fetch_go ? 1'b0 : (fb || fetch_done_b);
      end
      if (acc_hs) begin
        i <= i_nxt;
        l <= l_nxt;
        r <= r_nxt;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fetch_req = (state == FETCH);
  assign mul_load  = (state == MUL_LOAD);
  assign mul_start = (state == MUL_WAIT);
  assign acc_req   = (state == ACC);
  assign acc_clear = (state == ACC) && (r == '0);

  // Indices are zero whenever the block is idle. Gating on busy also forces
  // the size outputs to zero outside a job.
  assign a_row      = i;
  assign a_col      = r;
  assign b_row      = r;
  assign b_col      = l;
  assign c_row      = i;
  assign c_col      = l;
  assign tile_rows  = busy ? clip(32'(TM), 32'(M) - 32'(i)) : '0;
  assign tile_inner = busy ? clip(32'(TK), 32'(P) - 32'(r)) : '0;
  assign tile_cols  = busy ? clip(32'(TN), 32'(N) - 32'(l)) : '0;

`ifdef MATMUL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      tile_cnt <= '0;
    end else if (start_ok) begin
      cyc_cnt  <= '0;
      tile_cnt <= '0;
    end else begin
      if (busy && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + 32'd1;
      if (acc_hs)                  tile_cnt <= tile_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tiled_matmul_ctrl.sv
// Directed testbench for tiled_matmul_ctrl.
// dut  : default geometry (4x4x4, 2x2x2 tiles)
// dut5 : M=5, TM=2 (exercises row-edge clipping)
// Handshakes are recorded at ACC exit and compared against hand-written tables.
module tb_tiled_matmul_ctrl;
  localparam int W = 10;

  typedef struct packed {
    logic [W-1:0] i, l, r;
    logic         clr;
    logic [W-1:0] rows, inner, cols;
    logic         coh;   // a_row==c_row, b_row==a_col, b_col==c_col
  } hs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---- default DUT ----
  logic start, abort;
  logic auto_fa, auto_fb, auto_mul, auto_acc;
  logic man_fa, man_fb, man_md, man_ad;
  logic busy, done, fetch_req, mul_load, mul_start, acc_req, acc_clear;
  logic fetch_done_a, fetch_done_b, mul_done, acc_done;
  logic [W-1:0] a_row, a_col, b_row, b_col, c_row, c_col;
  logic [W-1:0] tile_rows, tile_inner, tile_cols;
`ifdef MATMUL_PERF_CNT_EN
  logic [31:0]  cyc_cnt;
  logic [W-1:0] tile_cnt;
`endif

  assign fetch_done_a = auto_fa  ? fetch_req : man_fa;
  assign fetch_done_b = auto_fb  ? fetch_req : man_fb;
  assign mul_done     = auto_mul ? mul_start : man_md;
  assign acc_done     = auto_acc ? acc_req   : man_ad;

  tiled_matmul_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .fetch_req(fetch_req), .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
    .fetch_done_a(fetch_done_a), .fetch_done_b(fetch_done_b),
    .tile_rows(tile_rows), .tile_inner(tile_inner), .tile_cols(tile_cols),
    .mul_load(mul_load), .mul_start(mul_start), .mul_done(mul_done),
    .acc_req(acc_req), .acc_clear(acc_clear), .c_row(c_row), .c_col(c_col),
    .acc_done(acc_done)
`ifdef MATMUL_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .tile_cnt(tile_cnt)
`endif
  );

  // ---- M=5 DUT, zero-latency responders ----
  logic start5, abort5;
  logic busy5, done5, fetch_req5, mul_load5, mul_start5, acc_req5, acc_clear5;
  logic [W-1:0] a_row5, a_col5, b_row5, b_col5, c_row5, c_col5;
  logic [W-1:0] tile_rows5, tile_inner5, tile_cols5;
`ifdef MATMUL_PERF_CNT_EN
  logic [31:0]  cyc_cnt5;
  logic [W-1:0] tile_cnt5;
`endif

  tiled_matmul_ctrl #(.M(5), .TM(2)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .abort(abort5), .busy(busy5), .done(done5),
    .fetch_req(fetch_req5), .a_row(a_row5), .a_col(a_col5), .b_row(b_row5), .b_col(b_col5),
    .fetch_done_a(fetch_req5), .fetch_done_b(fetch_req5),
    .tile_rows(tile_rows5), .tile_inner(tile_inner5), .tile_cols(tile_cols5),
    .mul_load(mul_load5), .mul_start(mul_start5), .mul_done(mul_start5),
    .acc_req(acc_req5), .acc_clear(acc_clear5), .c_row(c_row5), .c_col(c_col5),
    .acc_done(acc_req5)
`ifdef MATMUL_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt5), .tile_cnt(tile_cnt5)
`endif
  );

  // ---- monitors ----
  hs_t q[$], q5[$];
  int  done_hi = 0, done_hi5 = 0;

  always @(negedge clk) begin
    if (acc_req && acc_done)
      q.push_back({c_row, c_col, a_col, acc_clear, tile_rows, tile_inner, tile_cols,
                   (a_row == c_row) && (b_row == a_col) && (b_col == c_col)});
    if (acc_req5)
      q5.push_back({c_row5, c_col5, a_col5, acc_clear5, tile_rows5, tile_inner5, tile_cols5,
                    (a_row5 == c_row5) && (b_row5 == a_col5) && (b_col5 == c_col5)});
    if (done)  done_hi  <= done_hi + 1;
    if (done5) done_hi5 <= done_hi5 + 1;
  end

  // ---- checking ----
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_q(input string nm, input hs_t got[$], input hs_t exp[$]);
    chk({nm, "_count"}, 128'(got.size()), 128'(exp.size()));
    foreach (exp[k])
      if (k < got.size()) chk($sformatf("%s_hs%0d", nm, k), 128'(got[k]), 128'(exp[k]));
  endtask

  function automatic logic [127:0] outs();
    return 128'({busy, done, fetch_req, mul_load, mul_start, acc_req, acc_clear,
                 a_row, a_col, b_row, b_col, c_row, c_col, tile_rows, tile_inner, tile_cols});
  endfunction

  function automatic logic [127:0] outs5();
    return 128'({busy5, done5, fetch_req5, mul_load5, mul_start5, acc_req5, acc_clear5,
                 a_row5, a_col5, b_row5, b_col5, c_row5, c_col5, tile_rows5, tile_inner5, tile_cols5});
  endfunction

`ifdef MATMUL_PERF_CNT_EN
  logic [W-1:0] tile_at_done;
`endif

  // Wait, bounded, for the done pulse of the default DUT, then step into IDLE.
  task automatic wait_done(input string nm);
    int cyc = 0;
    while (!done && cyc < 500) begin @(negedge clk); cyc++; end
    chk({nm, "_done_seen"}, 128'(done), 128'(1));
`ifdef MATMUL_PERF_CNT_EN
    tile_at_done = tile_cnt;
`endif
    @(negedge clk);
  endtask

  task automatic run_job(input string nm);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(nm);
  endtask

  hs_t exp_def[$], exp5[$];

  initial begin
    int d0, nms, cyc;
    logic prev_ms;

    // {i, l, r, clr, rows, inner, cols, coh}, in handshake order
    exp_def = '{
      '{0,0,0,1,2,2,2,1}, '{0,0,2,0,2,2,2,1}, '{0,2,0,1,2,2,2,1}, '{0,2,2,0,2,2,2,1},
      '{2,0,0,1,2,2,2,1}, '{2,0,2,0,2,2,2,1}, '{2,2,0,1,2,2,2,1}, '{2,2,2,0,2,2,2,1}};
    exp5 = '{
      '{0,0,0,1,2,2,2,1}, '{0,0,2,0,2,2,2,1}, '{0,2,0,1,2,2,2,1}, '{0,2,2,0,2,2,2,1},
      '{2,0,0,1,2,2,2,1}, '{2,0,2,0,2,2,2,1}, '{2,2,0,1,2,2,2,1}, '{2,2,2,0,2,2,2,1},
      '{4,0,0,1,1,2,2,1}, '{4,0,2,0,1,2,2,1}, '{4,2,0,1,1,2,2,1}, '{4,2,2,0,1,2,2,1}};

    auto_fa = 1; auto_fb = 1; auto_mul = 1; auto_acc = 1;
    man_fa = 0; man_fb = 0; man_md = 0; man_ad = 0;
    start = 0; abort = 0; start5 = 0; abort5 = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 128'(0));
    chk("reset_outs_m5", outs5(), 128'(0));
`ifdef MATMUL_PERF_CNT_EN
    chk("reset_perf", 128'({cyc_cnt, tile_cnt}), 128'(0));
`endif
    rst = 0;
    @(negedge clk);

    // Default job: 8 handshakes, one single-cycle done pulse
    q.delete(); d0 = done_hi;
    run_job("def");
    check_q("def", q, exp_def);
    chk("def_done_width", 128'(done_hi - d0), 128'(1));
    chk("def_idle", 128'({busy, fetch_req, acc_req}), 128'(0));
`ifdef MATMUL_PERF_CNT_EN
    chk("perf_tile_at_done", 128'(tile_at_done), 128'(8));
    chk("perf_cyc", 128'(cyc_cnt), 128'(33));
`endif

    // M=5 edge clipping: rows 2,2,1 and 12 handshakes
    q5.delete(); d0 = done_hi5;
    @(negedge clk); start5 = 1;
    @(negedge clk); start5 = 0;
    cyc = 0;
    while (!done5 && cyc < 500) begin @(negedge clk); cyc++; end
    chk("m5_done_seen", 128'(done5), 128'(1));
    @(negedge clk);
    check_q("m5", q5, exp5);
    chk("m5_done_width", 128'(done_hi5 - d0), 128'(1));

    // Split fetch acknowledges, with stale pulses in IDLE first
    auto_fa = 0; auto_fb = 0;
    @(negedge clk); man_fa = 1; man_fb = 1;
    @(negedge clk); man_fa = 0; man_fb = 0;
    q.delete();
    start = 1;
    @(negedge clk); start = 0;                            // FETCH cycle 0
    chk("fetch_c0", 128'(fetch_req), 128'(1));
    @(negedge clk); man_fa = 1;                           // cycle 1
    @(negedge clk); man_fa = 0;                           // cycle 2
    chk("fetch_c2_hold", 128'({fetch_req, mul_load}), 128'(2'b10));
    @(negedge clk);                                       // cycle 3
    chk("fetch_c3_hold", 128'({fetch_req, mul_load}), 128'(2'b10));
    @(negedge clk); man_fb = 1;                           // cycle 4
    chk("fetch_c4_hold", 128'({fetch_req, mul_load}), 128'(2'b10));
    @(negedge clk); man_fb = 0;                           // MUL_LOAD expected
    chk("mul_load_entry", 128'({fetch_req, mul_load}), 128'(2'b01));
    @(negedge clk);
    chk("mul_load_1cyc", 128'({mul_load, mul_start}), 128'(2'b01));
    auto_fa = 1; auto_fb = 1;
    wait_done("split");
    check_q("split", q, exp_def);

    // Abort during the 3rd MUL_WAIT; mul_done asserted alongside abort
    auto_mul = 0; man_md = 0;
    q.delete(); d0 = done_hi; nms = 0; prev_ms = 0; cyc = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    while (nms < 3 && cyc < 200) begin
      if (mul_start && !prev_ms) nms++;
      prev_ms = mul_start;
      man_md = mul_start && (nms < 3);
      if (nms < 3) begin @(negedge clk); cyc++; end
    end
    chk("abort_reached_mw3", 128'(nms), 128'(3));
    abort = 1; man_md = 1;
    @(negedge clk); abort = 0; man_md = 0;
    chk("abort_idle", 128'({busy, done, fetch_req, mul_load, mul_start, acc_req, acc_clear}), 128'(0));
    chk("abort_hs_before", 128'(q.size()), 128'(2));
    repeat (5) @(negedge clk);
    chk("abort_no_done", 128'(done_hi - d0), 128'(0));
    auto_mul = 1;
    q.delete();
    run_job("post_abort");
    check_q("post_abort", q, exp_def);
`ifdef MATMUL_PERF_CNT_EN
    chk("perf_tile_post_abort", 128'(tile_at_done), 128'(8));
`endif

    // start pulsed while in ACC is ignored
    auto_acc = 0; man_ad = 0;
    q.delete(); d0 = done_hi; cyc = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    while (!acc_req && cyc < 50) begin @(negedge clk); cyc++; end
    chk("acc_reached", 128'(acc_req), 128'(1));
    start = 1;
    @(negedge clk); start = 0;
    auto_acc = 1;
    wait_done("start_in_acc");
    check_q("start_in_acc", q, exp_def);
    chk("start_in_acc_one_done", 128'(done_hi - d0), 128'(1));

    // rst while in FETCH
    auto_fa = 0; man_fa = 0; d0 = done_hi;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("rst_pre_fetch", 128'(fetch_req), 128'(1));
    #2 rst = 1;
    #1 chk("rst_mid_outs", outs(), 128'(0));
`ifdef MATMUL_PERF_CNT_EN
    chk("rst_mid_perf", 128'({cyc_cnt, tile_cnt}), 128'(0));
`endif
    @(negedge clk); rst = 0; auto_fa = 1;
    repeat (6) @(negedge clk);
    chk("rst_no_done", 128'({busy, 32'(done_hi - d0)}), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tiled_matmul_ctrl.md
TILED_MATMUL_CTRL -- requirements
Module: tiled_matmul_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, 16, element width passed to the datapath (no arithmetic in this block).
REQ-002 SHALL have parameters M, P, N, defaults 4, 4, 4, meaning C(MxN) = A(MxP) x B(PxN); each value is >= 1 and <= 1023.
REQ-003 SHALL have parameters TM, TK, TN, defaults 2, 2, 2, giving the tile rows, inner and tile cols; each value is >= 1.
REQ-004 SHALL have parameter IDX_W, 10, the width of every coordinate and size port.
REQ-005 SHALL have ports clk in 1 (clock) and rst in 1; rst is asynchronous and active-high.
REQ-006 SHALL have ports start in 1 (begin job), abort in 1 (cancel job), busy out 1 (job active) and done out 1 (job complete pulse).
REQ-007 SHALL have ports fetch_req out 1, a_row/a_col/b_row/b_col out IDX_W (tile origins), fetch_done_a in 1 and fetch_done_b in 1.
REQ-008 SHALL have ports tile_rows/tile_inner/tile_cols out IDX_W, giving the valid extent of the current tile.
REQ-009 SHALL have ports mul_load out 1, mul_start out 1 and mul_done in 1.
REQ-010 SHALL have ports acc_req out 1, acc_clear out 1, c_row/c_col out IDX_W and acc_done in 1.

Function
REQ-011 SHALL use states IDLE, FETCH, MUL_LOAD, MUL_WAIT, ACC and DONE.
REQ-012 SHALL sample start only in IDLE; start=1 -> FETCH next cycle with i=l=r=0; start outside IDLE is ignored.
REQ-013 SHALL hold fetch_req=1 in FETCH and latch each fetch_done independently (the two may arrive in different cycles); when both are latched -> MUL_LOAD, then the latches clear.
REQ-014 SHALL drive a_row=i, a_col=r, b_row=r, b_col=l, c_row=i and c_col=l, stable from FETCH entry until the ACC exit.
REQ-015 SHALL compute tile_rows=min(TM,M-i), tile_inner=min(TK,P-r) and tile_cols=min(TN,N-l), with no wrap past matrix edges.
REQ-016 SHALL assert mul_load for exactly one cycle in MUL_LOAD, then -> MUL_WAIT.
REQ-017 SHALL hold mul_start=1 in MUL_WAIT until mul_done=1 is sampled, then -> ACC.
REQ-018 SHALL hold acc_req=1 in ACC until acc_done=1; acc_clear=1 throughout ACC iff r==0.
REQ-019 SHALL advance at ACC exit, inner-most first:
  - r+=TK; if r+TK>=P then r=0 and l+=TN;
  - if additionally l+TN>=N then l=0 and i+=TM;
  - if additionally i+TM>=M -> DONE; otherwise -> FETCH.
REQ-020 SHALL pulse done for one cycle in DONE, then -> IDLE; busy=1 in every state except IDLE.
REQ-021 SHALL respond to abort=1 in any non-IDLE state by going to IDLE next cycle with all request outputs low and no done pulse; abort has priority over done inputs in the same cycle.
REQ-022 SHALL ignore fetch_done/mul_done/acc_done outside their consuming state; stale pulses have no effect.
REQ-023 SHALL produce ceil(M/TM)*ceil(N/TN)*ceil(P/TK) ACC handshakes per job.

Reset
REQ-024 SHALL, on rst, force IDLE, i=l=r=0, all coordinate/size outputs 0, busy=done=fetch_req=mul_load=mul_start=acc_req=acc_clear=0, and clear the fetch latches.
REQ-025 SHALL treat rst mid-job as abandoning the job; no done follows reset release.

Configuration
REQ-026 SHALL, with MATMUL_PERF_CNT_EN defined, add outputs cyc_cnt (32 bits, counts busy cycles, saturates at 2^32-1) and tile_cnt (IDX_W bits, counts ACC handshakes); both clear on rst and on an accepted start, and hold after done.
REQ-027 SHALL, without MATMUL_PERF_CNT_EN, omit both ports and counters; all other behaviour is identical.

Verification
REQ-028 Defaults, zero-latency responders, start pulse -> 8 ACC handshakes in order (i,l,r) (0,0,0),(0,0,2),(0,2,0),...,(2,2,2) -> one done pulse; acc_clear only when r=0.
REQ-029 M=5, TM=2, others default -> tile_rows sequence 2,2,1 at i=0,2,4; 12 handshakes; no coordinate >= 5.
REQ-030 fetch_done_a at FETCH+1, fetch_done_b at FETCH+4 -> MUL_LOAD entered exactly the cycle after fetch_done_b; mul_load is high for 1 cycle.
REQ-031 abort during the 3rd MUL_WAIT -> IDLE next cycle, busy=0, no done; a new start then runs a full 8-handshake job.
REQ-032 start pulsed during ACC is ignored; rst mid-FETCH -> all outputs at reset values; MATMUL_PERF_CNT_EN with defaults -> tile_cnt=8 at done.
